result_serializer: RTL

Downstream output stage of the watchdog datapath. Accepts one eigen-result (kappa, inv_kappa, regime) from the core on a start pulse and emits it as a framed byte stream on the 8-bit output pins. A 4-phase valid/ack handshake with the external host paces the transfer. An ack timeout aborts a stalled frame so the chip never hangs on a dead host.

---
 rtl/watchdog_pkg.sv | 52 +++++
 rtl/result_serializer_ack_sync.sv | 28 ++
 rtl/result_serializer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/watchdog_pkg.sv
// Shared definitions for the watchdog datapath output stage.
//   ser_state_t     : result_serializer FSM states
//   ERR_BYTE        : byte presented on out_byte while a frame is aborted
//   FRAME_LEN_*     : frame lengths in bytes (full result / no-result frame)
//   REGIME_NONE     : regime code meaning "no valid result"
//   frame_byte()    : selects byte idx of a frame from its fields
package watchdog_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        RELEASE = 3'd2,
        DONE    = 3'd3,
        ABORT   = 3'd4
    } ser_state_t;

    localparam logic [7:0] ERR_BYTE        = 8'hEE;
    localparam int         FRAME_LEN_FULL  = 10;
    localparam int         FRAME_LEN_SHORT = 2;
    localparam logic [2:0] REGIME_NONE     = 3'b000;

    // The last index of a frame is always the checksum, whatever the frame
    // length, so it is tested before the positional byte map.
    function automatic logic [7:0] frame_byte(
        input logic [3:0]  idx,
        input logic [3:0]  last_idx,
        input logic [7:0]  hdr,
        input logic [31:0] word_a,
        input logic [31:0] word_b,
        input logic [7:0]  chk
    );
        logic [7:0] b;
        if (idx == last_idx) begin
            b = chk;
        end else begin
            case (idx)
                4'd0:    b = hdr;
                4'd1:    b = word_a[31:24];
                4'd2:    b = word_a[23:16];
                4'd3:    b = word_a[15:8];
                4'd4:    b = word_a[7:0];
                4'd5:    b = word_b[31:24];
                4'd6:    b = word_b[23:16];
                4'd7:    b = word_b[15:8];
                4'd8:    b = word_b[7:0];
                default: b = chk;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/result_serializer_ack_sync.sv
// ack_sync: two-flop synchronizer for the asynchronous host_ack pin.
//   clk      in  : destination clock
//   rst_n    in  : asynchronous active-low reset, output resets to 0
//   async_in in  : asynchronous input
//   sync_out out : input resynchronised to clk (2 edges of latency)
module ack_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= async_in;
            sync_reg <= meta_reg;
        end
    end

    assign sync_out = sync_reg;

endmodule

// File: rtl/result_serializer.sv
// result_serializer: latches one eigen-result on start and sends it as a
// framed byte stream, paced by a 4-phase valid/ack handshake with the host.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : one-cycle pulse, result inputs valid
//   regime/word_a/b : result to send (regime 0 => header+checksum only)
//   host_ack        : asynchronous host acknowledge
//   busy            : frame in progress
//   out_byte        : current frame byte (8'hEE while aborting)
//   out_valid       : out_byte valid, held until acknowledged
//   done            : one-cycle pulse at end of frame (normal or aborted)
//   err             : last frame aborted by ack timeout, sticky until next start
module result_serializer #(
    parameter int         ACK_TIMEOUT = 1024,
    parameter logic [3:0] HDR_TAG     = 4'hA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  regime,
    input  logic [31:0] word_a,
    input  logic [31:0] word_b,
    input  logic        host_ack,
    output logic        busy,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    output logic        done,
    output logic        err
);
    import watchdog_pkg::*;

    localparam int            TW         = $clog2(ACK_TIMEOUT + 1);
    // Counter reads ACK_TIMEOUT-1 on the last permitted cycle of a state.
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    ser_state_t    state_reg, state_next;
    logic [3:0]    idx_reg, idx_next;
    logic [7:0]    xor_reg, xor_next;
    logic [TW-1:0] timer_reg;
    logic [2:0]    regime_reg;
    logic [31:0]   word_a_reg, word_b_reg;
    logic          start_pend_reg;

    logic          busy_reg, busy_next;
    logic [7:0]    out_byte_reg, out_byte_next;
    logic          out_valid_reg, out_valid_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;

    logic          ack_s;
    logic          accept;
    logic          timeout;
    logic [3:0]    last_idx;
    logic [7:0]    hdr_byte;
    logic [7:0]    cur_byte;

    ack_sync u_ack_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (host_ack),
        .sync_out (ack_s)
    );

    // A start is taken whenever the FSM is idle or finishing a frame (so a
    // start during the done pulse is not lost); the frame begins one edge
    // later from the pending flag, which keeps outputs one cycle behind start.
    assign accept   = start && !start_pend_reg &&
                      (state_reg == IDLE || state_reg == DONE || state_reg == ABORT);
    assign timeout  = (timer_reg == TIMER_LAST);
    assign last_idx = (regime_reg == REGIME_NONE) ? 4'(FRAME_LEN_SHORT - 1)
                                                  : 4'(FRAME_LEN_FULL - 1);
    assign hdr_byte = {HDR_TAG, 1'b0, regime_reg};
    assign cur_byte = frame_byte(idx_reg, last_idx, hdr_byte, word_a_reg, word_b_reg, xor_reg);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        xor_next   = xor_reg;
        case (state_reg)
            IDLE: begin
                if (start_pend_reg) state_next = SEND;
            end
            SEND: begin
                // An ack on the final permitted cycle still counts.
                if (ack_s) begin
                    xor_next   = xor_reg ^ cur_byte;
                    state_next = RELEASE;
                end else if (timeout) begin
                    state_next = ABORT;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    if (idx_reg == last_idx) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx_reg + 4'd1;
                        state_next = SEND;
                    end
                end else if (timeout) begin
                    state_next = ABORT;
                end
            end
            DONE:    state_next = IDLE;
            ABORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (accept) begin
            idx_next = 4'd0;
            xor_next = 8'h00;
        end
    end

    // Output decode from the next state, so every output is a flop that
    // changes on the same edge as the state it describes.
    always_comb begin
        busy_next      = (state_next != IDLE);
        out_valid_next = (state_next == SEND);
        done_next      = (state_next == DONE) || (state_next == ABORT);
        out_byte_next  = out_byte_reg;
        case (state_next)
            IDLE:    out_byte_next = 8'h00;
            SEND:    out_byte_next = frame_byte(idx_next, last_idx, hdr_byte,
                                                word_a_reg, word_b_reg, xor_next);
            ABORT:   out_byte_next = ERR_BYTE;
            default: out_byte_next = out_byte_reg;  // RELEASE/DONE hold the byte
        endcase
        if (accept) begin
            err_next = 1'b0;
        end else if (state_next == ABORT) begin
            err_next = 1'b1;
        end else begin
            err_next = err_reg;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg        <= 4'd0;
            xor_reg        <= 8'h00;
            timer_reg      <= '0;
            regime_reg     <= 3'b000;
            word_a_reg     <= 32'h0;
            word_b_reg     <= 32'h0;
            start_pend_reg <= 1'b0;
            busy_reg       <= 1'b0;
            out_byte_reg   <= 8'h00;
            out_valid_reg  <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            idx_reg <= idx_next;
            xor_reg <= xor_next;
            if (state_next != state_reg) begin
                timer_reg <= '0;
            end else if (state_reg == SEND || state_reg == RELEASE) begin
                timer_reg <= timer_reg + 1'b1;
            end else begin
                timer_reg <= '0;
            end
            if (accept) begin
                regime_reg     <= regime;
                word_a_reg     <= word_a;
                word_b_reg     <= word_b;
                start_pend_reg <= 1'b1;
            end else if (state_reg == IDLE) begin
                start_pend_reg <= 1'b0;
            end
            busy_reg      <= busy_next;
            out_byte_reg  <= out_byte_next;
            out_valid_reg <= out_valid_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    assign busy      = busy_reg;
    assign out_byte  = out_byte_reg;
    assign out_valid = out_valid_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule
